// File: rtl/neuron_mac_accumulator.sv
// rtl/neuron_mac_accumulator.sv - Q4.4 multiply-accumulate neuron stage with saturating valid/ready output
// Optional build macro: NEURON_MAC_ROUND_EN (round half up in FIN instead of floor truncation)
module neuron_mac_accumulator #(
   parameter int N_INPUTS  = 4,
   parameter int ACC_WIDTH = 20,
   parameter int FRAC      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] x,
   input  logic signed [7:0] w,
   input  logic signed [7:0] bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [7:0] z_value
);

   typedef enum logic [1:0] {ACC, FIN, OUT} state_t;

   localparam logic [4:0]        LAST  = 5'(N_INPUTS - 1);
   localparam logic signed [7:0] Z_MAX = 8'sh7F;
   localparam logic signed [7:0] Z_MIN = 8'sh80;
`ifdef NEURON_MAC_ROUND_EN
   localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} <<< (FRAC - 1);
`endif

   state_t                      state;
   logic signed [ACC_WIDTH-1:0] acc;
   logic [4:0]                  count;
   logic signed [7:0]           bias_reg;

   logic signed [15:0]          product;
   logic signed [ACC_WIDTH-1:0] product_ext;
   logic signed [ACC_WIDTH:0]   bias_wide;
   logic signed [ACC_WIDTH:0]   sum;
   logic signed [ACC_WIDTH:0]   sum_adj;
   logic signed [ACC_WIDTH:0]   q;
   logic signed [7:0]           z_next;
   logic                        beat;

   assign in_ready    = (state == ACC);
   assign beat        = in_valid && in_ready;
   assign product     = x * w;
   assign product_ext = {{(ACC_WIDTH-16){product[15]}}, product};
   assign bias_wide   = {{(ACC_WIDTH-7){bias_reg[7]}}, bias_reg};

   // Final sum in Q.8, rescale to Q4.4 and clamp to the signed 8-bit range
   always_comb begin
      sum = {acc[ACC_WIDTH-1], acc} + (bias_wide <<< FRAC);
`ifdef NEURON_MAC_ROUND_EN
      sum_adj = sum + HALF;
`else
      sum_adj = sum;
`endif
      q = sum_adj >>> FRAC;
      if (!q[ACC_WIDTH] && (|q[ACC_WIDTH-1:7])) begin
         z_next = Z_MAX;
      end else if (q[ACC_WIDTH] && !(&q[ACC_WIDTH-1:7])) begin
         z_next = Z_MIN;
      end else begin
         z_next = q[7:0];
      end
   end

   // Accumulate beats, finalize once, then hold the result until downstream takes it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ACC;
         acc       <= '0;
         count     <= '0;
         bias_reg  <= '0;
         z_value   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (beat) begin
                  if (count == 5'd0) begin
                     bias_reg <= bias;
                     acc      <= product_ext;
                  end else begin
                     acc <= acc + product_ext;
                  end
                  if (count == LAST) begin
                     count <= '0;
                     state <= FIN;
                  end else begin
                     count <= count + 5'd1;
                  end
               end
            end
            FIN: begin
               z_value   <= z_next;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  state     <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// tb/tb_neuron_mac_accumulator.sv - scoreboard bench for neuron_mac_accumulator
module tb_neuron_mac_accumulator;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] x;
   logic signed [7:0] w;
   logic signed [7:0] bias;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] z_value;

   int n_checks = 0;
   int n_fail   = 0;
   logic signed [7:0] exp_q[$];

   neuron_mac_accumulator #(.N_INPUTS(4), .ACC_WIDTH(20), .FRAC(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .w(w), .bias(bias), .out_valid(out_valid),
      .out_ready(out_ready), .z_value(z_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every output transfer is compared against the oldest expected result
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d, expected no transfer", z_value);
         end else begin
            check("z_value", int'(z_value), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_beat(input logic [7:0] xv, input logic [7:0] wv, input logic [7:0] bv);
      int waited;
      waited = 0;
      x = xv; w = wv; bias = bv; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("beat_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // xs/ws hold four beats, leftmost byte first
   task automatic send_eval(input logic [31:0] xs, input logic [31:0] ws, input logic [7:0] bv,
                            input logic [7:0] ev, input bit push, input bit timing);
      if (push) exp_q.push_back(ev);
      for (int i = 0; i < 4; i++) send_beat(xs[31-8*i -: 8], ws[31-8*i -: 8], bv);
      if (timing) begin
         check("fin_out_valid_low", int'(out_valid), 0);
         check("fin_in_ready_low", int'(in_ready), 0);
         @(posedge clk); #1;
         check("out_valid_rise", int'(out_valid), 1);
         @(posedge clk); #1;
         check("out_valid_one_cycle", int'(out_valid), 0);
         check("in_ready_after_xfer", int'(in_ready), 1);
      end
   endtask

   task automatic wait_out_valid();
      int waited;
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("out_valid_timeout", int'(out_valid), 1);
   endtask

   initial begin
      int waited;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; w = '0; bias = '0;
      #12;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_z_value", int'(z_value), 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      send_eval({8'd16, 8'd16, 8'd16, 8'd16}, {8'd16, 8'd16, 8'd16, 8'd16}, 8'd0, 8'd64, 1, 1);
`ifdef NEURON_MAC_ROUND_EN
      send_eval({8'd16, 8'd16, 8'd16, 8'd8}, {8'd16, 8'd16, 8'd16, 8'd1}, 8'h00, 8'd49, 1, 1);
      send_eval({8'd16, 8'd16, 8'd16, 8'd8}, {8'd16, 8'd16, 8'd16, 8'd1}, 8'hFF, 8'd48, 1, 1);
      send_eval({8'd16, 8'd16, 8'd16, 8'd8}, {8'd16, 8'd16, 8'd16, 8'd1}, 8'hF0, 8'd33, 1, 1);
      send_eval({8'hF8, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd0, 8'd0, 8'd0}, 8'h00, 8'd0, 1, 1);
`else
      send_eval({8'd16, 8'd16, 8'd16, 8'd8}, {8'd16, 8'd16, 8'd16, 8'd1}, 8'h00, 8'd48, 1, 1);
      send_eval({8'd16, 8'd16, 8'd16, 8'd8}, {8'd16, 8'd16, 8'd16, 8'd1}, 8'hFF, 8'd47, 1, 1);
      send_eval({8'd16, 8'd16, 8'd16, 8'd8}, {8'd16, 8'd16, 8'd16, 8'd1}, 8'hF0, 8'd32, 1, 1);
      send_eval({8'hF8, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd0, 8'd0, 8'd0}, 8'h00, 8'hFF, 1, 1);
`endif
      send_eval({4{8'h7F}}, {4{8'h7F}}, 8'h7F, 8'h7F, 1, 1);
      send_eval({4{8'h80}}, {4{8'h7F}}, 8'h80, 8'h80, 1, 1);

      // Backpressure: result held, extra beats refused
      out_ready = 1'b0;
      send_eval({4{8'd8}}, {4{8'd16}}, 8'd16, 8'd48, 1, 0);
      wait_out_valid();
      x = 8'd100; w = 8'd100; bias = 8'd100; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_z_value", int'(z_value), 48);
         check("bp_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid_drop", int'(out_valid), 0);
      check("bp_in_ready_back", int'(in_ready), 1);
      send_eval({4{8'd16}}, {4{8'd16}}, 8'd0, 8'd64, 1, 1);

      // Reset mid-evaluation
      send_beat(8'd16, 8'd16, 8'd0);
      send_beat(8'd16, 8'd16, 8'd0);
      #2 rst = 1'b0;
      #1;
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_out_valid", int'(out_valid), 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      send_eval({4{8'd16}}, {4{8'd16}}, 8'd16, 8'd80, 1, 1);

      // Reset while holding a result: it is lost
      out_ready = 1'b0;
      send_eval({4{8'd16}}, {4{8'd16}}, 8'd0, 8'd0, 0, 0);
      wait_out_valid();
      #2 rst = 1'b0;
      #1;
      check("outrst_out_valid", int'(out_valid), 0);
      check("outrst_in_ready", int'(in_ready), 1);
      @(negedge clk); rst = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      send_eval({4{8'd16}}, {4{8'd8}}, 8'd0, 8'd32, 1, 1);

      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
